// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch/issue unit feeding the control-unit decoder. It holds the
//   fetch PC, issues one outstanding read at a time to program memory (which
//   may answer after any number of cycles) and presents each returned word as
//   opcode + operand under a valid/ready handshake. It also supports PC
//   redirects and stops on HLT (opcode 6'b111111).
//
//   Optional build macro: FETCH_NOP_SKIP_EN
//     When defined, a response whose opcode is NOP (6'b000000) is never
//     presented. The unit advances fetch_pc and refetches directly.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-high reset
//   run               : level input; starts fetching from IDLE
//   imem_addr/req     : read address and one-cycle request pulse
//   imem_rdata/rvalid : read response data and strobe
//   opcode/operand/pc : presented instruction fields and their address
//   inst_valid/ready  : decoder handshake
//   redirect/_pc      : one-cycle PC redirect request and its target
//   halted            : high while in HALT
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_rvalid,
    output logic [5:0]        opcode,
    output logic [INST_W-7:0] operand,
    output logic [PC_W-1:0]   pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              halted
);

    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_NOP = 6'b000000;

`ifdef FETCH_NOP_SKIP_EN
    localparam bit NOP_SKIP = 1'b1;
`else
    localparam bit NOP_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
    logic              imem_req_q, imem_req_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [INST_W-7:0] operand_q, operand_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              halted_q, halted_d;

    logic [5:0] rdata_op;
    logic       transfer;

    assign rdata_op = imem_rdata[INST_W-1 -: 6];
    // inst_valid_q is only ever set in HOLD, so this is a HOLD-state transfer.
    assign transfer = inst_valid_q & inst_ready;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        imem_addr_d  = imem_addr_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        halted_d     = halted_q;

        case (state_q)
            IDLE:  if (run) state_d = FETCH;
            FETCH: state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (NOP_SKIP && rdata_op == OP_NOP) begin
                        fetch_pc_d = fetch_pc_q + 1'b1;
                        state_d    = FETCH;
                    end else begin
                        opcode_d     = rdata_op;
                        operand_d    = imem_rdata[INST_W-7:0];
                        pc_d         = fetch_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    inst_valid_d = 1'b0;
                    if (opcode_q == OP_HLT) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            DRAIN: if (imem_rvalid) state_d = FETCH;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything decided above. A request that is
        // already in flight must have its response swallowed in DRAIN.
        if (redirect && state_q != IDLE) begin
            fetch_pc_d   = redirect_pc;
            inst_valid_d = 1'b0;
            halted_d     = 1'b0;
            opcode_d     = opcode_q;
            operand_d    = operand_q;
            pc_d         = pc_q;
            case (state_q)
                FETCH:        state_d = DRAIN;
                WAIT, DRAIN:  state_d = imem_rvalid ? FETCH : DRAIN;
                default:      state_d = FETCH;
            endcase
        end

        // Request is registered so it is high exactly during the FETCH cycle.
        imem_req_d = (state_d == FETCH);
        if (imem_req_d) imem_addr_d = fetch_pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= '0;
            imem_addr_q  <= '0;
            imem_req_q   <= 1'b0;
            opcode_q     <= '0;
            operand_q    <= '0;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            imem_addr_q  <= imem_addr_d;
            imem_req_q   <= imem_req_d;
            opcode_q     <= opcode_d;
            operand_q    <= operand_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_req   = imem_req_q;
    assign opcode     = opcode_q;
    assign operand    = operand_q;
    assign pc         = pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. It contains a small program memory model
//   with programmable latency, a table of instruction words with their expected
//   decoded fields, and hand-written sequences for stall, wrap, redirect,
//   HLT, reset and NOP handling.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic [5:0]  opcode;
    logic [9:0]  operand;
    logic [7:0]  pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.PC_W(8), .INST_W(16)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .opcode(opcode), .operand(operand), .pc(pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Program memory model: answers each request after 'lat' cycles (lat>=1).
    logic [15:0] mem [256];
    int          lat = 1;
    int          cnt = 0;
    logic [7:0]  raddr = '0;

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req) begin
            if (lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem[imem_addr];
                cnt         <= 0;
            end else begin
                cnt   <= lat - 1;
                raddr <= imem_addr;
            end
        end else if (cnt == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mem[raddr];
            cnt         <= 0;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks the current cycle first, then steps; leaves the bench on the
    // negedge where imem_req is high.
    task automatic wait_req(input string name, input logic [7:0] exp_addr);
        bit found = 0;
        for (int k = 0; k < 50; k++) begin
            if (imem_req) begin found = 1; break; end
            @(negedge clk);
        end
        chk({name, "_req_seen"}, {31'd0, found}, 32'd1);
        if (found) chk({name, "_addr"}, {24'd0, imem_addr}, {24'd0, exp_addr});
    endtask

    task automatic wait_valid(output int n, output bit found);
        n = 0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (inst_valid) begin found = 1; break; end
        end
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        logic [5:0]  op;
        logic [9:0]  opd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  n;
        bit  f;
        bit  saw_v;
        bit  found;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0400;
        vecs[0] = '{8'h00, 16'h0400, 6'b000001, 10'h000};
        vecs[1] = '{8'h01, 16'h3812, 6'b001110, 10'h012};
        vecs[2] = '{8'h02, 16'h1234, 6'b000100, 10'h234};
        vecs[3] = '{8'h03, 16'hF7FF, 6'b111101, 10'h3FF};
        vecs[4] = '{8'h04, 16'h8001, 6'b100000, 10'h001};
        for (int i = 0; i < 5; i++) mem[vecs[i].addr] = vecs[i].word;
        mem[8'hFF] = 16'h0C05;
        mem[8'h40] = 16'h2ABC;
        mem[8'h41] = 16'hFC00;
        mem[8'h10] = 16'h5555;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outs", {imem_addr, imem_req, opcode, operand, pc, inst_valid, halted},
            '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);
        run = 1'b1;
        @(negedge clk);

        // Table-driven fetch of consecutive words
        for (int i = 0; i < 5; i++) begin
            wait_req($sformatf("v%0d", i), vecs[i].addr);
            wait_valid(n, f);
            chk($sformatf("v%0d_valid", i), {31'd0, f}, 32'd1);
            if (i == 0) chk("v0_latency", n, 2);
            chk($sformatf("v%0d_op", i), {26'd0, opcode}, {26'd0, vecs[i].op});
            chk($sformatf("v%0d_opd", i), {22'd0, operand}, {22'd0, vecs[i].opd});
            chk($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].addr});
            if (i == 1) begin
                // Decoder stall: everything must hold, no new request
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_hold", {imem_req, inst_valid, opcode, operand, pc},
                        {1'b0, 1'b1, 6'b001110, 10'h012, 8'h01});
                end
            end
            if (i < 4) accept();
        end

        // Redirect from HOLD to 0xFF, then check PC wrap to 0x00
        redirect = 1'b1; redirect_pc = 8'hFF;
        @(negedge clk);
        redirect = 1'b0;
        chk("rdr_hold_valid", {31'd0, inst_valid}, 32'd0);
        wait_req("rdr_hold", 8'hFF);
        wait_valid(n, f);
        chk("ff_fields", {f, opcode, operand, pc}, {1'b1, 6'b000011, 10'h005, 8'hFF});
        lat = 3;
        accept();
        wait_req("wrap", 8'h00);

        // Redirect while WAIT with a slow response: response must be dropped
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        saw_v = 0;
        found = 0;
        for (int k = 0; k < 12; k++) begin
            if (inst_valid) saw_v = 1;
            if (imem_req) begin found = 1; break; end
            @(negedge clk);
        end
        lat = 1;
        chk("drain_no_valid", {31'd0, saw_v}, 32'd0);
        chk("drain_req_seen", {31'd0, found}, 32'd1);
        chk("drain_addr", {24'd0, imem_addr}, 32'h40);
        wait_valid(n, f);
        chk("x40_fields", {f, opcode, operand, pc}, {1'b1, 6'b001010, 10'h2BC, 8'h40});
        accept();

        // HLT then redirect out of HALT
        wait_req("hlt", 8'h41);
        wait_valid(n, f);
        chk("hlt_fields", {f, opcode, pc}, {1'b1, 6'b111111, 8'h41});
        accept();
        for (int k = 0; k < 5; k++) begin
            chk("halted", {halted, imem_req, inst_valid}, {1'b1, 1'b0, 1'b0});
            @(negedge clk);
        end
        redirect = 1'b1; redirect_pc = 8'h10;
        lat = 3;
        @(negedge clk);
        redirect = 1'b0;
        chk("unhalt", {halted, imem_req, imem_addr}, {1'b0, 1'b1, 8'h10});

        // Asynchronous reset during WAIT; late response must be ignored
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        #1;
        chk("async_rst", {imem_addr, imem_req, opcode, operand, pc, inst_valid, halted},
            '0);
        @(negedge clk);
        rst = 1'b0;
        saw_v = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (inst_valid || imem_req) saw_v = 1;
        end
        chk("rst_ignore_resp", {31'd0, saw_v}, 32'd0);

        // NOP at address 0: presented normally, or skipped with the option
        lat = 1;
        mem[0] = 16'h0000;
        run = 1'b1;
        @(negedge clk);
        wait_req("nop", 8'h00);
        wait_valid(n, f);
`ifdef FETCH_NOP_SKIP_EN
        chk("nop_first", {f, opcode, operand, pc}, {1'b1, 6'b001110, 10'h012, 8'h01});
`else
        chk("nop_first", {f, opcode, operand, pc}, {1'b1, 6'b000000, 10'h000, 8'h00});
`endif
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
